// File: rtl/quad_access_if.sv
// CPU-side request/response and quad_mem port bundle for quad_access.
// slave = the sequencer's view, master = the requester/memory view.
interface quad_access_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 12
);
    logic               i_valid;
    logic               o_ready;
    logic               i_wr;
    logic [1:0]         i_bank;
    logic [ADDR_SZ-1:0] i_addr;
    logic [DATA_SZ-1:0] i_t;
    logic [DATA_SZ-1:0] i_x;
    logic [DATA_SZ-1:0] i_y;
    logic [DATA_SZ-1:0] i_z;
    logic               o_done;
    logic               o_err;
    logic [DATA_SZ-1:0] o_t;
    logic [DATA_SZ-1:0] o_x;
    logic [DATA_SZ-1:0] o_y;
    logic [DATA_SZ-1:0] o_z;
    logic               o_cs_ram;
    logic               o_cs_rom0;
    logic               o_cs_rom1;
    logic               o_mem_wr;
    logic [ADDR_SZ-1:0] o_mem_addr;
    logic [1:0]         o_mem_field;
    logic [DATA_SZ-1:0] o_mem_data;
    logic [DATA_SZ-1:0] i_mem_data;

    modport slave (
        input  i_valid, i_wr, i_bank, i_addr, i_t, i_x, i_y, i_z, i_mem_data,
        output o_ready, o_done, o_err, o_t, o_x, o_y, o_z,
               o_cs_ram, o_cs_rom0, o_cs_rom1, o_mem_wr, o_mem_addr, o_mem_field, o_mem_data
    );

    modport master (
        output i_valid, i_wr, i_bank, i_addr, i_t, i_x, i_y, i_z, i_mem_data,
        input  o_ready, o_done, o_err, o_t, o_x, o_y, o_z,
               o_cs_ram, o_cs_rom0, o_cs_rom1, o_mem_wr, o_mem_addr, o_mem_field, o_mem_data
    );
endinterface

// File: rtl/quad_access.sv
// Sequences one whole-quad read or write into four field accesses on quad_mem.
// Latency: write done 5 cycles after accept, read 6, invalid bank 1.
// Backpressure: o_ready low from accept until the o_done cycle; i_valid ignored while busy.
module quad_access #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    quad_access_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;

    state_t                   state;
    logic                     lat_rd;
    logic                     lat_err;
    logic [3:0][DATA_SZ-1:0]  wdat;
    logic [3:0][DATA_SZ-1:0]  cap;

    // o_mem_field doubles as the field counter; results land in cap and are
    // only published on completion so a reset mid-read never leaks a partial quad.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            lat_rd          <= 1'b0;
            lat_err         <= 1'b0;
            wdat            <= '0;
            cap             <= '0;
            bus.o_ready     <= 1'b1;
            bus.o_done      <= 1'b0;
            bus.o_err       <= 1'b0;
            bus.o_t         <= '0;
            bus.o_x         <= '0;
            bus.o_y         <= '0;
            bus.o_z         <= '0;
            bus.o_cs_ram    <= 1'b0;
            bus.o_cs_rom0   <= 1'b0;
            bus.o_cs_rom1   <= 1'b0;
            bus.o_mem_wr    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_field <= '0;
            bus.o_mem_data  <= '0;
        end else begin
            bus.o_done <= 1'b0;
            bus.o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        bus.o_ready     <= 1'b0;
                        wdat            <= {bus.i_z, bus.i_y, bus.i_x, bus.i_t};
                        lat_rd          <= !bus.i_wr;
                        bus.o_mem_addr  <= bus.i_addr;
                        bus.o_mem_field <= 2'd0;
                        if (bus.i_bank == 2'd3) begin
                            lat_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            lat_err        <= 1'b0;
                            state          <= bus.i_wr ? WR : RD;
                            bus.o_cs_ram   <= (bus.i_bank == 2'd0);
                            bus.o_cs_rom0  <= (bus.i_bank == 2'd1);
                            bus.o_cs_rom1  <= (bus.i_bank == 2'd2);
                            bus.o_mem_wr   <= bus.i_wr;
                            bus.o_mem_data <= bus.i_wr ? bus.i_t : '0;
                        end
                    end
                end
                RD: begin
                    // Read data trails the presented field by one cycle.
                    if (bus.o_mem_field != 2'd0)
                        cap[bus.o_mem_field - 2'd1] <= bus.i_mem_data;
                    bus.o_mem_field <= bus.o_mem_field + 2'd1;
                    if (bus.o_mem_field == 2'd3) begin
                        state         <= RD_TAIL;
                        bus.o_cs_ram  <= 1'b0;
                        bus.o_cs_rom0 <= 1'b0;
                        bus.o_cs_rom1 <= 1'b0;
                    end
                end
                RD_TAIL: begin
                    cap[3] <= bus.i_mem_data;
                    state  <= DONE;
                end
                WR: begin
                    bus.o_mem_field <= bus.o_mem_field + 2'd1;
                    if (bus.o_mem_field == 2'd3) begin
                        state          <= DONE;
                        bus.o_cs_ram   <= 1'b0;
                        bus.o_cs_rom0  <= 1'b0;
                        bus.o_cs_rom1  <= 1'b0;
                        bus.o_mem_wr   <= 1'b0;
                        bus.o_mem_data <= '0;
                    end else begin
                        bus.o_mem_data <= wdat[bus.o_mem_field + 2'd1];
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.o_ready <= 1'b1;
                    bus.o_done  <= 1'b1;
                    bus.o_err   <= lat_err;
                    if (lat_rd && !lat_err) begin
                        bus.o_t <= cap[0];
                        bus.o_x <= cap[1];
                        bus.o_y <= cap[2];
                        bus.o_z <= cap[3];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_access.sv
// Directed plus randomized quad requests against a transaction-level memory scoreboard.
module tb_quad_access;
    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 4 * (1 << AW);

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [DW-1:0] mem     [3][DEPTH];
    logic [DW-1:0] ref_mem [3][DEPTH];
    logic [3:0][DW-1:0] exp_res;

    quad_access_if #(.DATA_SZ(DW), .ADDR_SZ(AW)) bus ();

    quad_access #(.DATA_SZ(DW), .ADDR_SZ(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory: data for the address presented now appears next cycle.
    always @(posedge clk) begin : mem_model
        int b;
        b = -1;
        if (bus.o_cs_ram)       b = 0;
        else if (bus.o_cs_rom0) b = 1;
        else if (bus.o_cs_rom1) b = 2;
        if (b >= 0 && bus.o_mem_wr)
            mem[b][{bus.o_mem_addr, bus.o_mem_field}] <= bus.o_mem_data;
        if (b >= 0)
            bus.i_mem_data <= mem[b][{bus.o_mem_addr, bus.o_mem_field}];
        else
            bus.i_mem_data <= DW'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_t"}, bus.o_t, exp_res[0]);
        chk({tag, "_x"}, bus.o_x, exp_res[1]);
        chk({tag, "_y"}, bus.o_y, exp_res[2]);
        chk({tag, "_z"}, bus.o_z, exp_res[3]);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge.
    task automatic run_req(input bit wr, input logic [1:0] bank, input logic [AW-1:0] addr,
                           input logic [3:0][DW-1:0] dat, input bit toggle);
        int       lat;
        int       done_c;
        int       wr_cnt;
        bit       vbank;
        logic [2:0] exp_cs;
        vbank  = (bank != 2'd3);
        lat    = !vbank ? 1 : (wr ? 5 : 6);
        exp_cs = (bank == 2'd0) ? 3'b100 : (bank == 2'd1) ? 3'b010 : 3'b001;
        chk("ready_before", bus.o_ready, 1);
        bus.i_valid = 1'b1;
        bus.i_wr    = wr;
        bus.i_bank  = bank;
        bus.i_addr  = addr;
        bus.i_t     = dat[0];
        bus.i_x     = dat[1];
        bus.i_y     = dat[2];
        bus.i_z     = dat[3];
        @(negedge clk);
        done_c = -1;
        wr_cnt = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c < 4 && vbank) begin
                chk("cs_issue", {bus.o_cs_ram, bus.o_cs_rom0, bus.o_cs_rom1}, exp_cs);
                chk("field", bus.o_mem_field, c);
                chk("addr", bus.o_mem_addr, addr);
                chk("mem_wr_issue", bus.o_mem_wr, wr);
                if (wr) chk("wdata", bus.o_mem_data, dat[c]);
            end else begin
                chk("cs_quiet", {bus.o_cs_ram, bus.o_cs_rom0, bus.o_cs_rom1}, 0);
                chk("mem_wr_quiet", bus.o_mem_wr, 0);
            end
            if (bus.o_mem_wr) wr_cnt++;
            if (bus.o_done) begin
                done_c = c;
                break;
            end
            chk("busy_not_ready", bus.o_ready, 0);
            if (toggle) begin
                bus.i_valid = 1'($urandom);
                bus.i_wr    = 1'($urandom);
                bus.i_bank  = 2'($urandom);
                bus.i_addr  = AW'($urandom);
                bus.i_t     = DW'($urandom);
                bus.i_x     = DW'($urandom);
                bus.i_y     = DW'($urandom);
                bus.i_z     = DW'($urandom);
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        chk("done_latency", done_c, lat);
        chk("err", bus.o_err, !vbank);
        chk("ready_at_done", bus.o_ready, 1);
        chk("wr_cycles", wr_cnt, (wr && vbank) ? 4 : 0);
        if (vbank && wr)
            for (int k = 0; k < 4; k++) ref_mem[bank][{addr, 2'(k)}] = dat[k];
        if (vbank && !wr)
            for (int k = 0; k < 4; k++) exp_res[k] = ref_mem[bank][{addr, 2'(k)}];
        chk_results("result");
        @(negedge clk);
        chk("done_single", bus.o_done, 0);
    endtask

    initial begin
        logic [3:0][DW-1:0] d;
        logic [AW-1:0]      a;
        logic [1:0]         bk;
        n_cmp   = 0;
        n_bad   = 0;
        exp_res = '0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < DEPTH; i++) begin
                mem[b][i]     = DW'($urandom);
                ref_mem[b][i] = mem[b][i];
            end
        bus.i_valid = 1'b0;
        bus.i_wr    = 1'b0;
        bus.i_bank  = 2'd0;
        bus.i_addr  = '0;
        bus.i_t     = '0;
        bus.i_x     = '0;
        bus.i_y     = '0;
        bus.i_z     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_ready", bus.o_ready, 1);
        chk("rst_done", bus.o_done, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_cs", {bus.o_cs_ram, bus.o_cs_rom0, bus.o_cs_rom1}, 0);
        chk("rst_mem_wr", bus.o_mem_wr, 0);
        chk("rst_mem_addr", bus.o_mem_addr, 0);
        chk("rst_mem_field", bus.o_mem_field, 0);
        chk("rst_mem_data", bus.o_mem_data, 0);
        chk_results("rst_res");

        d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        run_req(1'b1, 2'd0, 12'h012, d, 1'b0);
        run_req(1'b0, 2'd0, 12'h012, '0, 1'b0);
        chk("readback_t", bus.o_t, 16'h1111);
        chk("readback_z", bus.o_z, 16'h4444);

        run_req(1'b0, 2'd2, 12'hFFF, '0, 1'b0);
        run_req(1'b0, 2'd3, 12'h123, '0, 1'b0);

        d = {16'hD00D, 16'hCAFE, 16'hBEEF, 16'hA5A5};
        run_req(1'b1, 2'd0, 12'h003, d, 1'b1);
        run_req(1'b0, 2'd0, 12'h003, '0, 1'b1);
        d = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
        run_req(1'b1, 2'd1, 12'h001, d, 1'b0);
        run_req(1'b0, 2'd1, 12'h001, '0, 1'b0);

        // Reset while field 2 of a write is on the bus.
        bus.i_valid = 1'b1;
        bus.i_wr    = 1'b1;
        bus.i_bank  = 2'd0;
        bus.i_addr  = 12'h055;
        bus.i_t     = 16'h5150;
        bus.i_x     = 16'h5151;
        bus.i_y     = 16'h5152;
        bus.i_z     = 16'h5153;
        repeat (3) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
        end
        chk("mid_field", bus.o_mem_field, 2);
        chk("mid_mem_wr", bus.o_mem_wr, 1);
        chk("mid_cs_ram", bus.o_cs_ram, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_mem_wr", bus.o_mem_wr, 0);
        chk("async_cs", {bus.o_cs_ram, bus.o_cs_rom0, bus.o_cs_rom1}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_done", bus.o_done, 0);
        end
        rst = 1'b0;
        ref_mem[0][{12'h055, 2'd0}] = 16'h5150;
        ref_mem[0][{12'h055, 2'd1}] = 16'h5151;
        exp_res = '0;
        @(negedge clk);
        chk("post_rst_ready", bus.o_ready, 1);
        chk("post_rst_done", bus.o_done, 0);
        chk_results("post_rst_res");

        for (int n = 0; n < 40; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? 12'hFFF : AW'($urandom_range(0, 7));
            bk = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            for (int k = 0; k < 4; k++) d[k] = DW'($urandom);
            run_req(1'($urandom), bk, a, d, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
